voice_allocator: RTL and testbench

- Shares a small pool of oscillator/envelope voices among the four key-on gates produced by the arpeggiator (or by the raw keys when the arpeggiator is bypassed).
- Tracks per-voice state (idle / hold / release), assigns new notes to free voices, retriggers re-pressed notes, and steals the oldest held voice when the pool is exhausted.
- Sits between the arpeggiator outputs and the voice datapath; the voice datapath consumes the gate, key-index and trigger outputs.

---
 rtl/synth_pkg.sv | 28 ++
 rtl/voice_slot.sv | 96 +++++++++
 rtl/voice_allocator.sv | 165 ++++++++++++++++
 tb/tb_voice_allocator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synth_pkg
//  Description : Shared types and default sizing for the voice allocator
//                slice (voice state encoding, key/voice counts, widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int DEF_NUM_KEYS   = 4;
    localparam int DEF_NUM_VOICES = 2;
    localparam int DEF_AGE_W      = 4;

    // Index width for a pool of n items; never narrower than one bit.
    function automatic int key_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_KEY_W = key_width(DEF_NUM_KEYS);

    typedef enum logic [1:0] {
        V_IDLE    = 2'd0,
        V_HOLD    = 2'd1,
        V_RELEASE = 2'd2
    } voice_state_t;

endpackage
`default_nettype wire

// File: rtl/voice_slot.sv
`default_nettype none
// ============================================================================
//  Module      : voice_slot
//  Description : One voice of the pool: state machine, release countdown,
//                saturating age counter and owned key index. Driven by
//                alloc / age_inc / key_fall strobes from the allocator.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_slot
    import synth_pkg::*;
#(
    parameter int KEY_W = DEF_KEY_W,
    parameter int AGE_W = DEF_AGE_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               i_alloc,
    input  logic [KEY_W-1:0]   i_new_key,
    input  logic               i_age_inc,
    input  logic               i_key_fall,
    input  logic [15:0]        i_release_len,
    output voice_state_t       o_state,
    output logic [KEY_W-1:0]   o_key,
    output logic [AGE_W-1:0]   o_age,
    output logic               o_trig
);

    localparam logic [AGE_W-1:0] c_age_max = {AGE_W{1'b1}};

    voice_state_t       r_state;
    voice_state_t       w_state_nxt;
    logic               w_rel_load;
    logic               w_rel_dec;
    logic [15:0]        r_rel_cnt;
    logic [KEY_W-1:0]   r_key;
    logic [AGE_W-1:0]   r_age;
    logic               r_trig;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= V_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state; an allocation overrides a same-cycle key fall.
    always_comb begin
        w_state_nxt = r_state;
        w_rel_load  = 1'b0;
        w_rel_dec   = 1'b0;
        if (i_alloc) begin
            w_state_nxt = V_HOLD;
        end else begin
            case (r_state)
                V_IDLE: ;
                V_HOLD: begin
                    if (i_key_fall) begin
                        w_rel_load  = 1'b1;
                        w_state_nxt = (i_release_len == 16'd0) ? V_IDLE : V_RELEASE;
                    end
                end
                V_RELEASE: begin
                    if (r_rel_cnt <= 16'd1) w_state_nxt = V_IDLE;
                    else                    w_rel_dec   = 1'b1;
                end
                default: w_state_nxt = V_IDLE;
            endcase
        end
    end

    // Release countdown, key ownership, age and trigger pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rel_cnt <= 16'd0;
            r_key     <= '0;
            r_age     <= '0;
            r_trig    <= 1'b0;
        end else begin
            r_trig <= i_alloc;
            if (w_rel_load)     r_rel_cnt <= i_release_len;
            else if (w_rel_dec) r_rel_cnt <= r_rel_cnt - 16'd1;
            if (i_alloc) begin
                r_key <= i_new_key;
                r_age <= '0;
            end else if (i_age_inc && (r_age != c_age_max)) begin
                r_age <= r_age + 1'b1;
            end
        end
    end

    assign o_state = r_state;
    assign o_key   = r_key;
    assign o_age   = r_age;
    assign o_trig  = r_trig;

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : voice_allocator
//  Description : Shares a pool of voices among key-on gates. Detects key
//                edges, queues pending presses, serves one per cycle (lowest
//                key first) and picks a victim voice: retrigger, idle,
//                oldest releasing, then oldest held (steal).
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_KEYS   = DEF_NUM_KEYS,
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int KEY_W      = key_width(NUM_KEYS),
    parameter int AGE_W      = DEF_AGE_W
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_KEYS-1:0]           key_on,
    input  logic [15:0]                   release_len,
    output logic [NUM_VOICES-1:0]         voice_gate,
    output logic [NUM_VOICES*KEY_W-1:0]   voice_key,
    output logic [NUM_VOICES-1:0]         voice_trig,
    output logic [NUM_VOICES-1:0]         voice_busy,
    output logic                          steal
);

    localparam int c_voice_w = key_width(NUM_VOICES);

    logic [NUM_KEYS-1:0]    r_key_q;
    logic [NUM_KEYS-1:0]    r_pending;
    logic                   r_steal;
    logic [NUM_KEYS-1:0]    w_rise;
    logic [NUM_KEYS-1:0]    w_fall;
    logic [NUM_KEYS-1:0]    w_cand;
    logic [NUM_KEYS-1:0]    w_served;

    voice_state_t           w_state [NUM_VOICES];
    logic [KEY_W-1:0]       w_vkey  [NUM_VOICES];
    logic [AGE_W-1:0]       w_age   [NUM_VOICES];
    logic [NUM_VOICES-1:0]  w_alloc;
    logic [NUM_VOICES-1:0]  w_age_inc;
    logic [NUM_VOICES-1:0]  w_key_fall;
    logic [NUM_VOICES-1:0]  w_trig;

    logic                   w_have_key;
    logic [KEY_W-1:0]       w_key_sel;
    logic                   w_retrig_hit, w_idle_hit, w_rel_hit, w_hold_hit;
    logic [c_voice_w-1:0]   w_retrig_v, w_idle_v, w_rel_v, w_hold_v, w_vsel;
    logic [AGE_W-1:0]       w_rel_age, w_hold_age;
    logic                   w_is_steal;

    assign w_rise = key_on & ~r_key_q;
    assign w_fall = ~key_on & r_key_q;
    // A queued press whose key has already been let go is dropped here.
    assign w_cand = (r_pending & ~w_fall) | w_rise;

    // Pick the key to serve and the voice that receives it.
    always_comb begin
        w_have_key   = 1'b0;
        w_key_sel    = '0;
        w_retrig_hit = 1'b0;
        w_retrig_v   = '0;
        w_idle_hit   = 1'b0;
        w_idle_v     = '0;
        w_rel_hit    = 1'b0;
        w_rel_v      = '0;
        w_rel_age    = '0;
        w_hold_hit   = 1'b0;
        w_hold_v     = '0;
        w_hold_age   = '0;
        w_vsel       = '0;
        w_is_steal   = 1'b0;
        w_alloc      = '0;
        w_served     = '0;

        for (int k = 0; k < NUM_KEYS; k++) begin
            if (!w_have_key && w_cand[k]) begin
                w_have_key = 1'b1;
                w_key_sel  = k[KEY_W-1:0];
            end
        end

        // Strict '>' keeps the lowest index on equal ages.
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!w_retrig_hit && (w_state[v] == V_RELEASE) && (w_vkey[v] == w_key_sel)) begin
                w_retrig_hit = 1'b1;
                w_retrig_v   = v[c_voice_w-1:0];
            end
            if (!w_idle_hit && (w_state[v] == V_IDLE)) begin
                w_idle_hit = 1'b1;
                w_idle_v   = v[c_voice_w-1:0];
            end
            if ((w_state[v] == V_RELEASE) && (!w_rel_hit || (w_age[v] > w_rel_age))) begin
                w_rel_hit = 1'b1;
                w_rel_v   = v[c_voice_w-1:0];
                w_rel_age = w_age[v];
            end
            if ((w_state[v] == V_HOLD) && (!w_hold_hit || (w_age[v] > w_hold_age))) begin
                w_hold_hit = 1'b1;
                w_hold_v   = v[c_voice_w-1:0];
                w_hold_age = w_age[v];
            end
        end

        if (w_retrig_hit)    w_vsel = w_retrig_v;
        else if (w_idle_hit) w_vsel = w_idle_v;
        else if (w_rel_hit)  w_vsel = w_rel_v;
        else                 w_vsel = w_hold_v;

        w_is_steal = w_have_key && !w_retrig_hit && !w_idle_hit && !w_rel_hit && w_hold_hit;

        if (w_have_key) begin
            w_alloc[w_vsel]     = 1'b1;
            w_served[w_key_sel] = 1'b1;
        end
    end

    // Edge history, pending queue and steal pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_key_q   <= '0;
            r_pending <= '0;
            r_steal   <= 1'b0;
        end else begin
            r_key_q   <= key_on;
            r_pending <= w_cand & ~w_served;
            r_steal   <= w_is_steal;
        end
    end

    generate
        for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
            assign w_age_inc[v]  = (w_state[v] != V_IDLE) && !w_alloc[v];
            assign w_key_fall[v] = w_fall[w_vkey[v]];

            voice_slot #(
                .KEY_W (KEY_W),
                .AGE_W (AGE_W)
            ) u_slot (
                .CLK           (CLK),
                .RESET         (RESET),
                .i_alloc       (w_alloc[v]),
                .i_new_key     (w_key_sel),
                .i_age_inc     (w_age_inc[v]),
                .i_key_fall    (w_key_fall[v]),
                .i_release_len (release_len),
                .o_state       (w_state[v]),
                .o_key         (w_vkey[v]),
                .o_age         (w_age[v]),
                .o_trig        (w_trig[v])
            );

            assign voice_gate[v]                = (w_state[v] == V_HOLD);
            assign voice_busy[v]                = (w_state[v] != V_IDLE);
            assign voice_key[v*KEY_W +: KEY_W]  = w_vkey[v];
        end
    endgenerate

    assign voice_trig = w_trig;
    assign steal      = r_steal;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_allocator
//  Description : Self-checking bench for voice_allocator (4 keys, 2 voices).
//                Directed scenarios plus randomized key traffic checked
//                against a behavioural pool model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int NV = 2;

    logic        CLK;
    logic        RESET;
    logic [3:0]  key_on;
    logic [15:0] release_len;
    logic [1:0]  voice_gate;
    logic [3:0]  voice_key;
    logic [1:0]  voice_trig;
    logic [1:0]  voice_busy;
    logic        steal;
    logic [10:0] dut_vec;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: 0 idle, 1 hold, 2 release
    int        m_st   [NV];
    int        m_key  [NV];
    int        m_age  [NV];
    int        m_cnt  [NV];
    int        m_trig [NV];
    bit        m_steal;
    bit [3:0]  m_kq;
    bit [3:0]  m_pend;

    voice_allocator #(.NUM_KEYS(4), .NUM_VOICES(2), .KEY_W(2), .AGE_W(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .key_on      (key_on),
        .release_len (release_len),
        .voice_gate  (voice_gate),
        .voice_key   (voice_key),
        .voice_trig  (voice_trig),
        .voice_busy  (voice_busy),
        .steal       (steal)
    );

    assign dut_vec = {voice_gate, voice_key, voice_trig, voice_busy, steal};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock of the pool as described in words: serve the lowest queued key,
    // choose retrigger / idle / oldest release / oldest hold.
    function automatic void model_clock(input bit [3:0] k, input bit r, input int rl);
        bit [3:0] rise, fall, cand;
        bit have, stl;
        int ks, vic, best;
        if (r) begin
            for (int v = 0; v < NV; v++) begin
                m_st[v] = 0; m_key[v] = 0; m_age[v] = 0; m_cnt[v] = 0; m_trig[v] = 0;
            end
            m_steal = 0; m_kq = 0; m_pend = 0;
            return;
        end
        rise = k & ~m_kq;
        fall = ~k & m_kq;
        cand = (m_pend & ~fall) | rise;
        have = 0; ks = 0; vic = -1; stl = 0;
        for (int i = 0; i < 4; i++) if (!have && cand[i]) begin have = 1; ks = i; end
        if (have) begin
            for (int v = 0; v < NV; v++) if (vic < 0 && m_st[v] == 2 && m_key[v] == ks) vic = v;
            for (int v = 0; v < NV; v++) if (vic < 0 && m_st[v] == 0) vic = v;
            if (vic < 0) begin
                best = -1;
                for (int v = 0; v < NV; v++) if (m_st[v] == 2 && m_age[v] > best) begin best = m_age[v]; vic = v; end
            end
            if (vic < 0) begin
                best = -1; stl = 1;
                for (int v = 0; v < NV; v++) if (m_st[v] == 1 && m_age[v] > best) begin best = m_age[v]; vic = v; end
            end
        end
        for (int v = 0; v < NV; v++) begin
            if (v == vic) begin
                m_st[v] = 1; m_key[v] = ks; m_age[v] = 0; m_trig[v] = 1;
            end else begin
                m_trig[v] = 0;
                if (m_st[v] != 0) m_age[v] = (m_age[v] < 15) ? m_age[v] + 1 : 15;
                if (m_st[v] == 1 && fall[m_key[v]]) begin
                    if (rl == 0) m_st[v] = 0;
                    else begin m_st[v] = 2; m_cnt[v] = rl; end
                end else if (m_st[v] == 2) begin
                    if (m_cnt[v] <= 1) m_st[v] = 0;
                    else m_cnt[v] = m_cnt[v] - 1;
                end
            end
        end
        m_steal = stl;
        m_pend  = cand;
        if (have) m_pend[ks] = 1'b0;
        m_kq = k;
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [1:0] g, t, b;
        logic [3:0] kk;
        g = '0; t = '0; b = '0; kk = '0;
        for (int v = 0; v < NV; v++) begin
            g[v] = (m_st[v] == 1);
            b[v] = (m_st[v] != 0);
            t[v] = (m_trig[v] != 0);
            kk[v*2 +: 2] = m_key[v][1:0];
        end
        return {g, kk, t, b, m_steal};
    endfunction

    // Drive inputs, take one clock edge, advance the model, settle.
    task automatic step(input logic [3:0] k, input logic r, input logic [15:0] rl);
        key_on = k; RESET = r; release_len = rl;
        @(posedge CLK);
        model_clock(k, r, int'(rl));
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'b1010, 1'b1, 16'd5);
            n_cmp++; if (dut_vec !== 11'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 000", dut_vec); end
            n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_single_note();
        step(4'b0000, 1'b1, 16'd2);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 16'd2);
        step(4'b0001, 1'b0, 16'd2);
        n_cmp++; if ({voice_gate, voice_trig, voice_busy, voice_key[1:0], steal} !== 9'b01_01_01_00_0) begin
            n_bad++; $display("FAIL single_alloc: got g%b t%b b%b k%0d s%b want g01 t01 b01 k0 s0", voice_gate, voice_trig, voice_busy, voice_key[1:0], steal); end
        step(4'b0001, 1'b0, 16'd2);
        n_cmp++; if ({voice_gate, voice_trig} !== 4'b01_00) begin
            n_bad++; $display("FAIL single_trig_pulse: got g%b t%b want g01 t00", voice_gate, voice_trig); end
    endtask

    task automatic test_steal();
        step(4'b0000, 1'b1, 16'd4);
        step(4'b0000, 1'b0, 16'd4);
        step(4'b0001, 1'b0, 16'd4);
        step(4'b0011, 1'b0, 16'd4);
        n_cmp++; if ({voice_gate, voice_trig, voice_key[3:2], steal} !== 7'b11_10_01_0) begin
            n_bad++; $display("FAIL steal_second_voice: got g%b t%b k1=%0d s%b want g11 t10 k1=1 s0", voice_gate, voice_trig, voice_key[3:2], steal); end
        step(4'b0111, 1'b0, 16'd4);
        n_cmp++; if ({voice_gate, voice_trig, voice_key, steal} !== 9'b11_01_0110_1) begin
            n_bad++; $display("FAIL steal_oldest: got g%b t%b k%b s%b want g11 t01 k0110 s1", voice_gate, voice_trig, voice_key, steal); end
        step(4'b0111, 1'b0, 16'd4);
        n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL steal_after: got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_chord();
        int steals;
        steals = 0;
        step(4'b0000, 1'b1, 16'd4);
        step(4'b0000, 1'b0, 16'd4);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0, 16'd4);
            steals += int'(steal);
            n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL chord_cycle%0d: got %h want %h", i, dut_vec, exp_vec()); end
        end
        n_cmp++; if (steals !== 2) begin n_bad++; $display("FAIL chord_steal_count: got %0d want 2", steals); end
        n_cmp++; if ({voice_key, voice_trig} !== 6'b1110_00) begin
            n_bad++; $display("FAIL chord_final: got k%b t%b want k1110 t00", voice_key, voice_trig); end
    endtask

    task automatic test_release();
        logic [1:0] want_busy [4];
        want_busy[0] = 2'b01; want_busy[1] = 2'b01; want_busy[2] = 2'b01; want_busy[3] = 2'b00;
        step(4'b0000, 1'b1, 16'd3);
        step(4'b0000, 1'b0, 16'd3);
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 16'd3);
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 1'b0, 16'd3);
            n_cmp++; if ({voice_gate, voice_busy} !== {2'b00, want_busy[i]}) begin
                n_bad++; $display("FAIL release_busy%0d: got g%b b%b want g00 b%b", i, voice_gate, voice_busy, want_busy[i]); end
        end
        // key1 on voice0, key0 on voice1; release key0 slowly, key1 instantly
        step(4'b0010, 1'b0, 16'd10);
        step(4'b0011, 1'b0, 16'd10);
        step(4'b0010, 1'b0, 16'd10);
        step(4'b0000, 1'b0, 16'd0);
        n_cmp++; if ({voice_gate, voice_busy} !== 4'b00_10) begin
            n_bad++; $display("FAIL release_zero_len: got g%b b%b want g00 b10", voice_gate, voice_busy); end
        step(4'b0001, 1'b0, 16'd0);
        n_cmp++; if ({voice_gate, voice_trig, voice_busy, voice_key[3:2], steal} !== 9'b10_10_10_00_0) begin
            n_bad++; $display("FAIL retrigger: got g%b t%b b%b k1=%0d s%b want g10 t10 b10 k1=0 s0", voice_gate, voice_trig, voice_busy, voice_key[3:2], steal); end
    endtask

    task automatic test_zero_release_and_drop();
        int steals;
        steals = 0;
        step(4'b0000, 1'b1, 16'd0);
        step(4'b0000, 1'b0, 16'd0);
        step(4'b0001, 1'b0, 16'd0);
        step(4'b0000, 1'b0, 16'd0);
        n_cmp++; if ({voice_gate, voice_busy} !== 4'b0000) begin
            n_bad++; $display("FAIL zero_release: got g%b b%b want g00 b00", voice_gate, voice_busy); end
        step(4'b1111, 1'b0, 16'd0); steals += int'(steal);
        step(4'b0111, 1'b0, 16'd0); steals += int'(steal);
        step(4'b0111, 1'b0, 16'd0); steals += int'(steal);
        step(4'b0111, 1'b0, 16'd0); steals += int'(steal);
        n_cmp++; if ({voice_key, voice_trig} !== 6'b0110_00) begin
            n_bad++; $display("FAIL dropped_pulse: got k%b t%b want k0110 t00", voice_key, voice_trig); end
        n_cmp++; if (steals !== 1) begin n_bad++; $display("FAIL dropped_steal_count: got %0d want 1", steals); end
    endtask

    task automatic test_reset_mid_hold();
        step(4'b0000, 1'b1, 16'd2);
        step(4'b0000, 1'b0, 16'd2);
        step(4'b0001, 1'b0, 16'd2);
        step(4'b0001, 1'b0, 16'd2);
        step(4'b0001, 1'b1, 16'd2);
        n_cmp++; if (dut_vec !== 11'd0) begin n_bad++; $display("FAIL midreset_clear: got %h want 000", dut_vec); end
        step(4'b0001, 1'b0, 16'd2);
        n_cmp++; if ({voice_gate, voice_trig, voice_busy, voice_key[1:0]} !== 8'b01_01_01_00) begin
            n_bad++; $display("FAIL midreset_realloc: got g%b t%b b%b k%0d want g01 t01 b01 k0", voice_gate, voice_trig, voice_busy, voice_key[1:0]); end
    endtask

    task automatic test_random();
        logic [3:0] k;
        logic       r;
        k = 4'b0000;
        step(4'b0000, 1'b1, 16'd0);
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) k[b] = ~k[b];
            r = ($urandom_range(0, 99) == 0);
            step(k, r, 16'($urandom_range(0, 6)));
            n_cmp++; if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL random_cycle%0d: got %h want %h (keys %b)", i, dut_vec, exp_vec(), k); end
        end
    endtask

    initial begin
        RESET = 1'b1; key_on = 4'b0000; release_len = 16'd0;
        test_reset();
        test_single_note();
        test_steal();
        test_chord();
        test_release();
        test_zero_release_and_drop();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
